// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_if
// Purpose  : Bundles the LSQ request handshake, the 2-lane data-memory port
//            and the completion/writeback outputs of lsu_mem_ctrl.
// Ports    : none (signal container). Modports:
//              slave  - the controller (consumes req_*, mem_rdata)
//              master - the surrounding LSQ + memory + scoreboard side
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    // LSQ head entry
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_is_store;
    logic [1:0]                     req_warp;
    logic [3:0]                     req_dest_reg;
    logic [3:0]                     req_mask;
    logic [7:0][ADDR_WIDTH-1:0]     req_addr;
    logic [7:0][DATA_WIDTH-1:0]     req_wdata;

    // Data-memory port, one lane pair per beat
    logic                           mem_en;
    logic                           mem_we;
    logic [1:0][ADDR_WIDTH-1:0]     mem_addr;
    logic [1:0][DATA_WIDTH-1:0]     mem_wdata;
    logic [1:0][DATA_WIDTH-1:0]     mem_rdata;

    // Completion and writeback
    logic                           busy;
    logic                           done_out;
    logic                           done_is_store;
    logic [1:0]                     done_warp;
    logic [3:0]                     done_dest_reg;
    logic [3:0]                     done_mask;
    logic [7:0][DATA_WIDTH-1:0]     reg_write_data;

    modport slave (
        input  req_valid, req_is_store, req_warp, req_dest_reg, req_mask, req_addr, req_wdata,
        output req_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, done_out, done_is_store, done_warp, done_dest_reg, done_mask, reg_write_data
    );

    modport master (
        output req_valid, req_is_store, req_warp, req_dest_reg, req_mask, req_addr, req_wdata,
        input  req_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, done_out, done_is_store, done_warp, done_dest_reg, done_mask, reg_write_data
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Serialises one LSQ entry (8 lane addresses, optional store data)
//            onto a 2-lane data-memory port, one enabled lane pair per beat,
//            gathers load returns into an 8-lane buffer and pulses done with
//            the entry's tags.
// Ports    : clk    - clock, all state on rising edge
//            reset  - asynchronous active-low reset
//            bus    - lsu_mem_ctrl_if.slave (request, memory, completion)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 1     // legal 1..3
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(MEM_LATENCY - 1);
    localparam int         TAG_TAIL   = MEM_LATENCY - 1;

    state_t                         state_q, state_d;
    logic [1:0]                     ptr_q, ptr_d;
    logic [1:0]                     drain_q, drain_d;
    logic                           ready_q;

    // Latched entry; also serves as the done_* tags, which therefore stay
    // stable from completion until the next accept.
    logic                           is_store_q;
    logic [1:0]                     warp_q;
    logic [3:0]                     dest_q;
    logic [3:0]                     mask_q;
    logic [7:0][ADDR_WIDTH-1:0]     addr_q;
    logic [7:0][DATA_WIDTH-1:0]     wdata_q;
    logic [7:0][DATA_WIDTH-1:0]     buf_q;

    // Read-tag pipeline: a load beat's pair index travels alongside the
    // memory access and names the buffer lanes when its data emerges.
    logic [MEM_LATENCY-1:0]         tag_vld_q;
    logic [MEM_LATENCY-1:0][1:0]    tag_ptr_q;

    logic                           w_accept;
    logic                           w_issue;
    logic [1:0]                     w_first_ptr;
    logic [1:0]                     w_next_ptr;
    logic                           w_has_next;

    // ------------------------------------------------------------------
    // Mask scans: lowest set pair of the incoming entry, and the next set
    // pair above the current pointer of the latched entry.
    // ------------------------------------------------------------------
    always_comb begin
        w_first_ptr = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_mask[k]) begin
                w_first_ptr = 2'(k);
            end
        end
        w_has_next = 1'b0;
        w_next_ptr = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k] && (2'(k) > ptr_q)) begin
                w_has_next = 1'b1;
                w_next_ptr = 2'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        drain_d  = drain_q;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    w_accept = 1'b1;
                    ptr_d    = w_first_ptr;
                    state_d  = (bus.req_mask == 4'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_has_next) begin
                    ptr_d = w_next_ptr;
                end else if (is_store_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LAST;
                end
            end
            S_DRAIN: begin
                // The final DRAIN cycle is the one in which the last
                // return emerges from the tag pipeline.
                if (drain_q == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            drain_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drain_q <= drain_d;
            // Registered so that ready stays low while reset is asserted
            // and rises on the first edge after release.
            ready_q <= (state_d == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Entry latch, tag pipeline and load result buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_store_q <= 1'b0;
            warp_q     <= 2'd0;
            dest_q     <= 4'd0;
            mask_q     <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (w_accept) begin
            is_store_q <= bus.req_is_store;
            warp_q     <= bus.req_warp;
            dest_q     <= bus.req_dest_reg;
            mask_q     <= bus.req_mask;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            tag_ptr_q <= '0;
        end else begin
            tag_vld_q[0] <= w_issue && !is_store_q;
            tag_ptr_q[0] <= ptr_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ptr_q[i] <= tag_ptr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
        end else if (w_accept) begin
            // Lanes of masked pairs are never written and so read back 0.
            buf_q <= '0;
        end else if (tag_vld_q[TAG_TAIL]) begin
            buf_q[{tag_ptr_q[TAG_TAIL], 1'b0}] <= bus.mem_rdata[0];
            buf_q[{tag_ptr_q[TAG_TAIL], 1'b1}] <= bus.mem_rdata[1];
        end
    end

    // ------------------------------------------------------------------
    // Outputs; memory bus is forced to 0 whenever no beat is issued.
    // ------------------------------------------------------------------
    assign w_issue            = (state_q == S_ISSUE);

    assign bus.req_ready      = ready_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.mem_en         = w_issue;
    assign bus.mem_we         = w_issue && is_store_q;
    assign bus.mem_addr       = w_issue ? {addr_q[{ptr_q, 1'b1}], addr_q[{ptr_q, 1'b0}]} : '0;
    assign bus.mem_wdata      = w_issue ? {wdata_q[{ptr_q, 1'b1}], wdata_q[{ptr_q, 1'b0}]} : '0;

    assign bus.done_out       = (state_q == S_DONE);
    assign bus.done_is_store  = is_store_q;
    assign bus.done_warp      = warp_q;
    assign bus.done_dest_reg  = dest_q;
    assign bus.done_mask      = mask_q;
    assign bus.reg_write_data = buf_q;

endmodule
`default_nettype wire
